fault_sweep_checker: RTL and testbench
======================================

// Module: fault_sweep_checker
// PURPOSE
//  Self-contained exhaustive stimulus generator and fault comparator for stuck-at fault labs.
//  - Drives every input combination 0..2^N_IN-1 onto a golden circuit and a faulty circuit in parallel.
//  - Holds each vector for SETTLE cycles, then compares the two output buses.
//  - Reports the mismatch count, the first failing vector and a sticky per-output fail mask.
//  - Sits between the lab top level and the pair of combinational circuits under test (e.g. good vs SA0/SA1 variants).
// PARAMETERS
//  N_IN    3  width of the stimulus vector; the sweep covers 2^N_IN vectors
//  N_OUT   2  width of each compared output bus
//  SETTLE  1  cycles each vector is held; the compare is sampled on the last of them; legal range >=1
// PORTS
//  clk               in   1          rising-edge clock
//  rst_n             in   1          asynchronous active-low reset
//  start             in   1          one-cycle pulse; begins a sweep when not busy
//  abort             in   1          one-cycle pulse; cancels a running sweep
//  vec_out           out  N_IN       stimulus to both circuits, MSB = first circuit input (A)
//  golden_in         in   N_OUT      outputs of the fault-free circuit
//  dut_in            in   N_OUT      outputs of the faulty circuit
//  busy              out  1          high while sweeping
//  done              out  1          high from sweep completion until the next start
//  mismatch_cnt      out  N_IN+1     number of vectors where golden_in != dut_in
//  first_fail_vec    out  N_IN       vector of the first mismatch
//  first_fail_valid  out  1          first_fail_vec holds a real mismatch
//  fail_mask         out  N_OUT      sticky OR of (golden_in ^ dut_in) over all sampled vectors
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous, any state):
//  - State goes to IDLE.
//  - All outputs and counters go to 0.
//  FSM states: IDLE, RUN, DONE.
//  IDLE or DONE, start=1:
//  - Next state is RUN; busy=1, done=0.
//  - vec_out=0, settle counter=0.
//  - mismatch_cnt, fail_mask, first_fail_vec and first_fail_valid are cleared.
//  RUN, holding a vector:
//  - Settle counter counts 0..SETTLE-1.
//  - When the count reaches SETTLE-1, the current vector is sampled.
//  RUN, sampling a vector (count = SETTLE-1):
//  - If golden_in != dut_in, mismatch_cnt increments.
//  - If golden_in != dut_in, fail_mask |= golden_in ^ dut_in.
//  - On a mismatch with first_fail_valid=0: first_fail_vec=vec_out, first_fail_valid=1.
//  - Then vec_out increments and the settle counter returns to 0.
//  Vector counter and wrap:
//  - The counter is N_IN+1 bits internally; vec_out is its low N_IN bits.
//  - After the sample of vector 2^N_IN-1: next state DONE, busy=0, done=1.
//  - On that transition vec_out wraps to 0.
//  Timing: the sweep is exactly 2^N_IN*SETTLE cycles in RUN; done rises on the following edge.
//  Results stay valid in DONE; they change only on the next start or on reset.
//  start while in RUN: ignored.
//  abort while in RUN:
//  - Next state IDLE; busy=0, done=0, vec_out=0.
//  - Partial result outputs hold their values.
//  abort and start in the same cycle: abort wins.
//  abort outside RUN: ignored.
//  mismatch_cnt never overflows, because its maximum is 2^N_IN.
//  Compare inputs are sampled only on sample cycles; values between sample cycles are ignored.
// STRUCTURE
//  - fault_sweep_pkg: state enum {IDLE, RUN, DONE}, function clog2 for the settle counter width.
//  - Sub-module sweep_counter: vector and settle counters plus the terminal flag.
//    Parameters N_IN and SETTLE; ports clk, rst_n, clr, en, vec, sample, last.
//  - The top level holds the FSM and the compare/accumulate registers.
// TESTING (N_IN=3, N_OUT=2, SETTLE=1 unless stated)
//  1. dut_in = golden_in, start pulse -> 8 RUN cycles, vec_out steps 0..7;
//     then done=1, mismatch_cnt=0, first_fail_valid=0, fail_mask=00.
//  2. golden F1 = A&B, dut F1 = 1 (SA1), F0 equal -> mismatch_cnt=6, first_fail_vec=000, fail_mask=10.
//  3. dut differs only at vec 101, both bits -> mismatch_cnt=1, first_fail_vec=101, fail_mask=11.
//  4. start re-pulsed mid-run -> ignored, sweep completes normally.
//     abort on RUN cycle 4 -> IDLE, busy=0, done=0, vec_out=0.
//  5. rst_n low mid-run for half a cycle -> all outputs 0 immediately.
//     A new start then yields a result identical to scenario 1.
//  6. SETTLE=3 -> each vector held 3 cycles; done rises on the edge after 24 RUN cycles;
//     the scenario 2 result is unchanged.

Source files
------------

// File: rtl/fault_sweep_pkg.sv
// Shared types and helpers for the stuck-at fault sweep checker.
package fault_sweep_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fault_sweep_checker_counter.sv
// Vector/settle counters for the sweep; sample marks the last settle cycle of a vector.
module sweep_counter
  import fault_sweep_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  output logic [N_IN-1:0] vec,
  output logic            sample,
  output logic            last
);

  localparam int SW = (clog2(SETTLE) < 1) ? 1 : clog2(SETTLE);
  localparam logic [SW-1:0] SET_MAX  = SW'(SETTLE - 1);
  localparam logic [SW-1:0] SET_ONE  = SW'(1);
  localparam logic [N_IN:0] VEC_MAX  = {1'b0, {N_IN{1'b1}}};
  localparam logic [N_IN:0] VEC_ONE  = (N_IN + 1)'(1);

  logic [SW-1:0] settle_q, settle_d;
  logic [N_IN:0] vec_q, vec_d;

  assign sample = (settle_q == SET_MAX);
  assign last   = sample && (vec_q == VEC_MAX);
  assign vec    = vec_q[N_IN-1:0];

  always_comb begin
    settle_d = settle_q;
    vec_d    = vec_q;
    if (clr) begin
      settle_d = '0;
      vec_d    = '0;
    end else if (en) begin
      if (sample) begin
        settle_d = '0;
        vec_d    = vec_q + VEC_ONE;
      end else begin
        settle_d = settle_q + SET_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= '0;
      vec_q    <= '0;
    end else begin
      settle_q <= settle_d;
      vec_q    <= vec_d;
    end
  end

endmodule

// File: rtl/fault_sweep_checker.sv
// Exhaustive golden-vs-faulty sweep: FSM plus mismatch count, first-fail capture and fail mask.
module fault_sweep_checker
  import fault_sweep_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  vec_out,
  input  logic [N_OUT-1:0] golden_in,
  input  logic [N_OUT-1:0] dut_in,
  output logic             busy,
  output logic             done,
  output logic [N_IN:0]    mismatch_cnt,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_valid,
  output logic [N_OUT-1:0] fail_mask
);

  localparam logic [N_IN:0] CNT_ONE = (N_IN + 1)'(1);

  state_e           state_q, state_d;
  logic [N_IN:0]    cnt_q, cnt_d;
  logic [N_OUT-1:0] mask_q, mask_d;
  logic [N_IN-1:0]  ffv_q, ffv_d;
  logic             ffval_q, ffval_d;
  logic             clr, en, sample, last;
  logic [N_IN-1:0]  vec;
  logic [N_OUT-1:0] diff;

  sweep_counter #(.N_IN(N_IN), .SETTLE(SETTLE)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .en     (en),
    .vec    (vec),
    .sample (sample),
    .last   (last)
  );

  assign diff = golden_in ^ dut_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    ffv_d   = ffv_q;
    ffval_d = ffval_q;
    clr     = 1'b0;
    en      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          clr     = 1'b1;
          cnt_d   = '0;
          mask_d  = '0;
          ffv_d   = '0;
          ffval_d = 1'b0;
        end
      end
      RUN: begin
        // abort drops the in-flight sample; partial results are kept
        if (abort) begin
          state_d = IDLE;
          clr     = 1'b1;
        end else begin
          en = 1'b1;
          if (sample) begin
            if (diff != '0) begin
              cnt_d  = cnt_q + CNT_ONE;
              mask_d = mask_q | diff;
              if (!ffval_q) begin
                ffv_d   = vec;
                ffval_d = 1'b1;
              end
            end
            if (last) begin
              state_d = DONE;
              clr     = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      ffv_q   <= '0;
      ffval_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      ffv_q   <= ffv_d;
      ffval_q <= ffval_d;
    end
  end

  assign vec_out          = vec;
  assign busy             = (state_q == RUN);
  assign done             = (state_q == DONE);
  assign mismatch_cnt     = cnt_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffval_q;
  assign fail_mask        = mask_q;

endmodule

// File: tb/tb_fault_sweep_checker.sv
// Randomized bench for fault_sweep_checker; SETTLE=1 and SETTLE=3 instances against a sweep-level model.
module tb_fault_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start1 = 1'b0, abort1 = 1'b0, start3 = 1'b0, abort3 = 1'b0;
  logic [2:0] vec1, vec3, ffv1, ffv3;
  logic [1:0] g1, d1, g3, d3, mask1, mask3;
  logic [3:0] cnt1, cnt3;
  logic       busy1, done1, ffval1, busy3, done3, ffval3;

  logic [1:0] gtab [8];
  logic [1:0] dtab [8];
  logic       noise_en = 1'b0;
  logic [1:0] noise_g = '0, noise_d = '0;

  assign g1 = gtab[vec1];
  assign d1 = dtab[vec1];
  assign g3 = noise_en ? noise_g : gtab[vec3];
  assign d3 = noise_en ? noise_d : dtab[vec3];

  fault_sweep_checker #(.N_IN(3), .N_OUT(2), .SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .vec_out(vec1),
    .golden_in(g1), .dut_in(d1), .busy(busy1), .done(done1), .mismatch_cnt(cnt1),
    .first_fail_vec(ffv1), .first_fail_valid(ffval1), .fail_mask(mask1)
  );

  fault_sweep_checker #(.N_IN(3), .N_OUT(2), .SETTLE(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .vec_out(vec3),
    .golden_in(g3), .dut_in(d3), .busy(busy3), .done(done3), .mismatch_cnt(cnt3),
    .first_fail_vec(ffv3), .first_fail_valid(ffval3), .fail_mask(mask3)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // st: 0 idle, 1 sweeping, 2 finished; k = cycles spent sweeping so far
  typedef struct { int st; int k; int cnt; int mask; int ffv; int ffval; } mdl_t;
  mdl_t m1 = '{0, 0, 0, 0, 0, 0};
  mdl_t m3 = '{0, 0, 0, 0, 0, 0};

  function automatic mdl_t step(input mdl_t m, input logic st_i, input logic ab_i, input int s);
    mdl_t r;
    int v;
    r = m;
    if (m.st == 1) begin
      if (ab_i) begin
        r.st = 0;
        r.k  = 0;
      end else begin
        if (m.k % s == s - 1) begin
          v = m.k / s;
          if (gtab[v] != dtab[v]) begin
            r.cnt++;
            r.mask = r.mask | int'(gtab[v] ^ dtab[v]);
            if (m.ffval == 0) begin
              r.ffv   = v;
              r.ffval = 1;
            end
          end
        end
        r.k = m.k + 1;
        if (r.k == 8 * s) begin
          r.st = 2;
          r.k  = 0;
        end
      end
    end else if (st_i) begin
      r = '{1, 0, 0, 0, 0, 0};
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 = '{0, 0, 0, 0, 0, 0};
      m3 = '{0, 0, 0, 0, 0, 0};
    end else begin
      m1 = step(m1, start1, abort1, 1);
      m3 = step(m3, start3, abort3, 3);
    end
  end

  // garbage on the compare inputs between sample cycles of the SETTLE=3 instance
  always @(negedge clk) begin
    noise_en = (m3.st == 1) && (m3.k % 3 != 2);
    noise_g  = 2'($urandom);
    noise_d  = 2'($urandom);
  end

  task automatic check_inst(input string tag, input mdl_t m, input int s, input logic [2:0] vec,
                            input logic busy, input logic done, input logic [3:0] cnt,
                            input logic [2:0] ffv, input logic ffval, input logic [1:0] mask);
    chk({tag, ".vec_out"}, vec, (m.st == 1) ? m.k / s : 0);
    chk({tag, ".busy"}, busy, m.st == 1);
    chk({tag, ".done"}, done, m.st == 2);
    chk({tag, ".mismatch_cnt"}, cnt, m.cnt);
    chk({tag, ".first_fail_vec"}, ffv, m.ffv);
    chk({tag, ".first_fail_valid"}, ffval, m.ffval);
    chk({tag, ".fail_mask"}, mask, m.mask);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_inst("s1", m1, 1, vec1, busy1, done1, cnt1, ffv1, ffval1, mask1);
      check_inst("s3", m3, 3, vec3, busy3, done3, cnt3, ffv3, ffval3, mask3);
    end
  end

  // golden: F1 = A&B, F0 = A^C with A the vector MSB
  task automatic set_mode(input int mode);
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      gtab[i] = {v[2] & v[1], v[2] ^ v[0]};
      case (mode)
        0: dtab[i] = gtab[i];
        1: dtab[i] = {1'b1, v[2] ^ v[0]};
        2: dtab[i] = (i == 5) ? ~gtab[i] : gtab[i];
        default: dtab[i] = ($urandom_range(0, 1) == 0) ? gtab[i] : 2'($urandom);
      endcase
    end
  endtask

  // called at a negedge; returns at the negedge where the first RUN cycle is visible
  task automatic pulse_start(input int inst);
    if (inst == 1) start1 = 1'b1; else start3 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic sweep(input int inst, input int exp_len, input bit chk_vec);
    int n;
    pulse_start(inst);
    n = 0;
    while (((inst == 1) ? busy1 : busy3) && n < 200) begin
      if (chk_vec) chk("vec_step", (inst == 1) ? vec1 : vec3, n / ((inst == 1) ? 1 : 3));
      n++;
      @(negedge clk);
    end
    chk("run_len", n, exp_len);
    chk("done_after_run", (inst == 1) ? done1 : done3, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int n;
    set_mode(0);
    repeat (2) @(negedge clk);
    chk("rst.vec_out", vec1, 0);
    chk("rst.busy", busy1, 0);
    chk("rst.done", done1, 0);
    chk("rst.cnt", cnt1, 0);
    chk("rst.valid", ffval1, 0);
    chk("rst.mask", mask1, 0);
    chk("rst.busy3", busy3, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: identical circuits
    sweep(1, 8, 1);
    chk("sc1.cnt", cnt1, 0);
    chk("sc1.valid", ffval1, 0);
    chk("sc1.mask", mask1, 0);

    // 2: F1 stuck-at-1
    set_mode(1);
    sweep(1, 8, 0);
    chk("sc2.cnt", cnt1, 6);
    chk("sc2.ffv", ffv1, 0);
    chk("sc2.valid", ffval1, 1);
    chk("sc2.mask", mask1, 2);
    chk("sc2.model_cnt", m1.cnt, 6);

    // 3: single differing vector
    set_mode(2);
    sweep(1, 8, 0);
    chk("sc3.cnt", cnt1, 1);
    chk("sc3.ffv", ffv1, 5);
    chk("sc3.mask", mask1, 3);
    chk("sc3.model_ffv", m1.ffv, 5);

    // 4a: start re-pulsed mid-run is ignored
    pulse_start(1);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (busy1 && n < 50) begin n++; @(negedge clk); end
    chk("sc4.restart_len", n, 6);
    chk("sc4.done", done1, 1);
    chk("sc4.cnt", cnt1, 1);

    // 4b: abort (with a simultaneous start) on RUN cycle 4
    set_mode(1);
    pulse_start(1);
    repeat (3) @(negedge clk);
    chk("sc4.vec_before_abort", vec1, 3);
    abort1 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    start1 = 1'b0;
    chk("sc4.abort_busy", busy1, 0);
    chk("sc4.abort_done", done1, 0);
    chk("sc4.abort_vec", vec1, 0);
    chk("sc4.partial_cnt", cnt1, 3);
    @(negedge clk);
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    chk("sc4.idle_abort_busy", busy1, 0);

    // 5: asynchronous reset mid-run
    pulse_start(1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("sc5.busy", busy1, 0);
    chk("sc5.vec_out", vec1, 0);
    chk("sc5.cnt", cnt1, 0);
    chk("sc5.mask", mask1, 0);
    chk("sc5.valid", ffval1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_mode(0);
    sweep(1, 8, 0);
    chk("sc5.cnt_after", cnt1, 0);
    chk("sc5.valid_after", ffval1, 0);
    chk("sc5.mask_after", mask1, 0);

    // random sweeps with stray start/abort pulses
    for (int it = 0; it < 25; it++) begin
      set_mode(3);
      pulse_start(1);
      n = 0;
      while (busy1 && n < 50) begin
        start1 = ($urandom_range(0, 7) == 0);
        abort1 = ($urandom_range(0, 24) == 0);
        @(negedge clk);
        start1 = 1'b0;
        abort1 = 1'b0;
        n++;
      end
      chk("rnd.ended", busy1, 0);
      abort1 = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      abort1 = 1'b0;
    end

    // 6: SETTLE=3 with noise between samples
    set_mode(1);
    sweep(3, 24, 1);
    chk("sc6.cnt", cnt3, 6);
    chk("sc6.ffv", ffv3, 0);
    chk("sc6.mask", mask3, 2);
    for (int it = 0; it < 4; it++) begin
      set_mode(3);
      sweep(3, 24, 0);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
